// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter/sequencer for the single register-file read port; returns data with rd_valid/ack.
// Latency: req seen in IDLE at edge k -> select during k+1 -> rd_valid/ack pulse in cycle k+2; one read per 3 cycles.
// Backpressure: none downstream; requesters hold req/req_num until their one-cycle ack pulse.
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_num,
    output logic [7:0]        decoded_read_num,
    input  logic [DW-1:0]     mux_data,
    output logic [NREQ-1:0]   ack,
    output logic              rd_valid,
    output logic [IDW-1:0]    rd_id,
    output logic [DW-1:0]     rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SEL, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gid;
    logic [2:0]     gnum;
    logic [2:0]     num_arr [NREQ];
    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [2:0]     win_num;
    logic [IDW-1:0] idx;
    int             j;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            num_arr[i] = req_num[3*i +: 3];
        end
    end

    // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first hit wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        win_num = '0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IDW'(j);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
                win_num = num_arr[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gid     <= '0;
            gnum    <= '0;
            rd_id   <= '0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            // gnum is frozen here so later req_num changes cannot affect the read.
            if (state == IDLE && win_vld) begin
                gid  <= win_id;
                gnum <= win_num;
            end
            if (state == SEL) begin
                rd_data <= mux_data;
                rd_id   <= gid;
            end
            if (state == RESP) begin
                rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_vld ? SEL : IDLE;
            SEL:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        decoded_read_num = 8'd0;
        ack              = '0;
        rd_valid         = 1'b0;
        busy             = 1'b0;
        case (state)
            SEL: begin
                decoded_read_num = 8'd1 << gnum;
                busy             = 1'b1;
            end
            RESP: begin
                ack[gid] = 1'b1;
                rd_valid = 1'b1;
                busy     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
